fp8_accumulator: RTL and testbench

//  Downstream of the 8-bit float multiplier in each systolic PE: adds every product into a running sum.

---
 rtl/fp8_accumulator_pkg.sv | 81 ++++++++
 rtl/fp8_accumulator_if.sv | 28 ++
 rtl/fp8_accumulator_norm_step.sv | 31 +++
 rtl/fp8_accumulator.sv | 174 +++++++++++++++++
 tb/tb_fp8_accumulator.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp8_accumulator_pkg.sv
// fp8_pkg: shared definitions for the 8-bit float accumulator.
//   Number format {S, E[2:0], F[3:0]}, value = (-1)^S * 1.F * 2^(E-BIAS).
//   8'h00 is the only zero encoding.
// Contents: format widths, internal datapath widths, FSM state enum,
//   unpack (code -> sign/unbiased exponent/mantissa with guard bits) and
//   pack (normalized mantissa -> code, with saturation/flush rules).
package fp8_pkg;

  localparam int EXP_W  = 3;
  localparam int FRAC_W = 4;
  localparam int BIAS   = 3;
  localparam int GUARD  = 2;

  localparam int CODE_W = 1 + EXP_W + FRAC_W;
  // Hidden one + stored fraction + guard bits.
  localparam int MANT_W = FRAC_W + GUARD + 1;
  // One extra bit on top for the carry out of a same-sign add.
  localparam int SUM_W  = MANT_W + 1;
  // Signed internal exponent: room for carry overflow and for up to
  // MANT_W-1 left shifts below the smallest encodable exponent.
  localparam int EI_W   = EXP_W + 2;

  localparam logic [CODE_W-1:0] FP8_ZERO = 8'h00;
  localparam logic [CODE_W-1:0] FP8_MAX  = 8'h7F;

  // Largest biased exponent field value.
  localparam logic signed [EI_W-1:0] EXP_TOP = EI_W'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EI_W-1:0]   exp;   // unbiased, two's complement
    logic [MANT_W-1:0] mant;  // {1, F, guard zeros}; all zero for the zero code
  } unpacked_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              ovf;
  } packed_t;

  function automatic unpacked_t unpack(input logic [CODE_W-1:0] x);
    unpacked_t u;
    u.sign = x[CODE_W-1];
    u.exp  = $signed({{(EI_W-EXP_W){1'b0}}, x[FRAC_W +: EXP_W]}) - EI_W'(BIAS);
    u.mant = (x == FP8_ZERO) ? '0 : {1'b1, x[FRAC_W-1:0], {GUARD{1'b0}}};
    return u;
  endfunction

  // mant must already be normalized (hidden one at bit MANT_W-1) or zero.
  // Guard bits are simply dropped.
  function automatic packed_t pack(input logic                   sign,
                                   input logic signed [EI_W-1:0] exp,
                                   input logic [SUM_W-1:0]       mant);
    packed_t                p;
    logic signed [EI_W-1:0] be;
    logic [FRAC_W-1:0]      frac;
    be     = exp + EI_W'(BIAS);
    frac   = mant[GUARD +: FRAC_W];
    p.code = FP8_ZERO;
    p.ovf  = 1'b0;
    if (mant != '0) begin
      if (be > EXP_TOP) begin
        p.code = {sign, FP8_MAX[CODE_W-2:0]};
        p.ovf  = 1'b1;
      end else if (!be[EI_W-1] && !(be == '0 && frac == '0)) begin
        // Negative exponents and the E=0/F=0 pattern (which would alias
        // the zero code) fall through and flush to zero without a flag.
        p.code = {sign, be[EXP_W-1:0], frac};
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fp8_accumulator_if.sv
// fp8_accumulator_if: start/done handshake and data bus of the accumulator.
//   clear     : synchronous sum clear, honoured only while idle
//   acc_start : level request; held high until acc_done, then dropped
//   prod_in   : product to add, captured with the start
//   acc_done  : result valid; held until acc_start goes low
//   acc_out   : running sum
//   busy      : accumulator not idle
//   ovf       : sticky saturation flag
// master = producer (multiplier side), slave = the accumulator.
interface fp8_accumulator_if;
  logic       clear;
  logic       acc_start;
  logic [7:0] prod_in;
  logic       acc_done;
  logic [7:0] acc_out;
  logic       busy;
  logic       ovf;

  modport master (
    output clear, acc_start, prod_in,
    input  acc_done, acc_out, busy, ovf
  );

  modport slave (
    input  clear, acc_start, prod_in,
    output acc_done, acc_out, busy, ovf
  );
endinterface

// File: rtl/fp8_accumulator_norm_step.sv
// fp8_norm_step: one combinational normalization step.
//   mant/exp           : current sum mantissa (carry bit on top) and exponent
//   mant_next/exp_next : mantissa/exponent after this step
//   done_norm          : result is normalized (or zero) after this step
// A carry is fixed with a single right shift and completes normalization;
// a missing leading one costs one left shift per call.
module fp8_norm_step
  import fp8_pkg::*;
(
  input  logic [SUM_W-1:0]       mant,
  input  logic signed [EI_W-1:0] exp,
  output logic [SUM_W-1:0]       mant_next,
  output logic signed [EI_W-1:0] exp_next,
  output logic                   done_norm
);

  always_comb begin
    mant_next = mant;
    exp_next  = exp;
    done_norm = 1'b1;
    if (mant[SUM_W-1]) begin
      mant_next = mant >> 1;
      exp_next  = exp + EI_W'(1);
    end else if (mant != '0 && !mant[SUM_W-2]) begin
      mant_next = mant << 1;
      exp_next  = exp - EI_W'(1);
      done_norm = 1'b0;
    end
  end

endmodule

// File: rtl/fp8_accumulator.sv
// fp8_accumulator: adds each 8-bit float product into a running sum.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fp8_accumulator_if (clear, acc_start, prod_in in;
//           acc_done, acc_out, busy, ovf out)
// Flow: IDLE captures operands, ALIGN lines up the smaller operand, ADD does
// the sign-magnitude add, NORM normalizes one bit per cycle, DONE presents
// the packed result until acc_start is released.
module fp8_accumulator
  import fp8_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  fp8_accumulator_if.slave bus
);

  state_t                 state_reg;
  logic [CODE_W-1:0]      sum_reg;
  logic [CODE_W-1:0]      acc_out_reg;
  logic                   acc_done_reg;
  logic                   busy_reg;
  logic                   ovf_reg;
  logic [CODE_W-1:0]      opa_reg;
  logic [CODE_W-1:0]      opb_reg;
  logic [MANT_W-1:0]      am_reg;
  logic [MANT_W-1:0]      bm_reg;
  logic                   as_reg;
  logic                   bs_reg;
  logic [SUM_W-1:0]       m_reg;
  logic signed [EI_W-1:0] e_reg;
  logic                   s_reg;

  // Alignment of the captured operands.
  unpacked_t              ua;
  unpacked_t              ub;
  logic signed [EI_W-1:0] ea;
  logic signed [EI_W-1:0] eb;
  logic signed [EI_W-1:0] e_big;
  logic [EI_W-1:0]        d;
  logic [MANT_W-1:0]      am_align;
  logic [MANT_W-1:0]      bm_align;

  always_comb begin
    ua       = unpack(opa_reg);
    ub       = unpack(opb_reg);
    ea       = ua.exp;
    eb       = ub.exp;
    am_align = ua.mant;
    bm_align = ub.mant;
    e_big    = ea;
    d        = '0;
    // Zero unpacks to the lowest exponent with a zero mantissa, so it never
    // wins the exponent comparison against a nonzero operand.
    if (ea >= eb) begin
      d        = ea - eb;
      bm_align = (d >= EI_W'(MANT_W)) ? '0 : (ub.mant >> d);
    end else begin
      d        = eb - ea;
      am_align = (d >= EI_W'(MANT_W)) ? '0 : (ua.mant >> d);
      e_big    = eb;
    end
  end

  // Sign-magnitude add; on a subtract the larger magnitude sets the sign.
  logic [SUM_W-1:0] sum_m;
  logic             sum_s;

  always_comb begin
    sum_m = '0;
    sum_s = as_reg;
    if (as_reg == bs_reg) begin
      sum_m = {1'b0, am_reg} + {1'b0, bm_reg};
    end else if (am_reg >= bm_reg) begin
      sum_m = {1'b0, am_reg} - {1'b0, bm_reg};
    end else begin
      sum_m = {1'b0, bm_reg} - {1'b0, am_reg};
      sum_s = bs_reg;
    end
  end

  logic [SUM_W-1:0]       norm_m;
  logic signed [EI_W-1:0] norm_e;
  logic                   norm_done;
  packed_t                result;

  fp8_norm_step u_norm_step (
    .mant      (m_reg),
    .exp       (e_reg),
    .mant_next (norm_m),
    .exp_next  (norm_e),
    .done_norm (norm_done)
  );

  // Packing the post-step value lets the final NORM cycle load DONE directly.
  assign result = pack(s_reg, norm_e, norm_m);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sum_reg      <= FP8_ZERO;
      acc_out_reg  <= FP8_ZERO;
      acc_done_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      am_reg       <= '0;
      bm_reg       <= '0;
      as_reg       <= 1'b0;
      bs_reg       <= 1'b0;
      m_reg        <= '0;
      e_reg        <= '0;
      s_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.clear) begin
            sum_reg <= FP8_ZERO;
            ovf_reg <= 1'b0;
          end
          if (bus.acc_start) begin
            // A simultaneous clear wins, so the captured sum is zero.
            opa_reg   <= bus.clear ? FP8_ZERO : sum_reg;
            opb_reg   <= bus.prod_in;
            busy_reg  <= 1'b1;
            state_reg <= ALIGN;
          end
        end
        ALIGN: begin
          am_reg    <= am_align;
          bm_reg    <= bm_align;
          as_reg    <= ua.sign;
          bs_reg    <= ub.sign;
          e_reg     <= e_big;
          state_reg <= ADD;
        end
        ADD: begin
          m_reg     <= sum_m;
          s_reg     <= sum_s;
          state_reg <= NORM;
        end
        NORM: begin
          m_reg <= norm_m;
          e_reg <= norm_e;
          if (norm_done) begin
            sum_reg      <= result.code;
            acc_out_reg  <= result.code;
            acc_done_reg <= 1'b1;
            if (result.ovf) begin
              ovf_reg <= 1'b1;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!bus.acc_start) begin
            acc_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.acc_done = acc_done_reg;
  assign bus.acc_out  = acc_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_fp8_accumulator.sv
// Testbench for fp8_accumulator: directed table, hand-written reset/hold
// sequences and randomized adds against a scaled-integer reference model.
module tb_fp8_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp8_accumulator_if bus ();

  fp8_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_sum  = 8'h00;
  logic       ref_ovf  = 1'b0;
  logic [7:0] last_out = 8'h00;

  typedef struct {
    logic [7:0] code;
    logic       ovf;
    int         lat;
  } ref_t;

  // Reference: both operands become integers on the grid of the larger
  // exponent with 6 fractional bits below the leading one (the smaller one
  // is truncated onto that grid), add them as signed integers, then locate
  // the leading one to get exponent, fraction and normalize-shift count.
  function automatic ref_t ref_add(input logic [7:0] a, input logic [7:0] b);
    ref_t r;
    int ea, eb, emax, ma, mb, s, mag, p, e, f;
    ea = int'(a[6:4]);
    eb = int'(b[6:4]);
    ma = (a == 8'h00) ? 0 : ((16 + int'(a[3:0])) * 4);
    mb = (b == 8'h00) ? 0 : ((16 + int'(b[3:0])) * 4);
    emax = (ea > eb) ? ea : eb;
    ma = ma >> (emax - ea);
    mb = mb >> (emax - eb);
    s = (a[7] ? -ma : ma) + (b[7] ? -mb : mb);
    mag = (s < 0) ? -s : s;
    r.code = 8'h00;
    r.ovf  = 1'b0;
    r.lat  = 3;
    if (mag == 0) return r;
    p = 0;
    for (int i = 0; i < 8; i++) if (mag[i]) p = i;
    e = p + emax - 6;
    f = (p >= 4) ? ((mag >> (p - 4)) & 15) : ((mag << (4 - p)) & 15);
    r.lat = 3 + ((p < 6) ? (6 - p) : 0);
    if (e > 7) begin
      r.code = {s < 0, 7'h7F};
      r.ovf  = 1'b1;
    end else if (e < 0 || (e == 0 && f == 0)) begin
      r.code = 8'h00;
    end else begin
      r.code = {s < 0, e[2:0], f[3:0]};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    ref_sum = 8'h00;
    ref_ovf = 1'b0;
    check("clear_ovf", bus.ovf, 0);
    check("clear_out_kept", bus.acc_out, last_out);
    $display("[TB] clear -> acc_out=%02h ovf=%0d", bus.acc_out, bus.ovf);
  endtask

  // One accumulate; co_clr raises clear together with acc_start, hold keeps
  // acc_start high for extra cycles after acc_done.
  task automatic apply(input logic [7:0] p, input logic pre_clr, input logic co_clr, input int hold);
    ref_t r;
    int   lat;
    if (pre_clr) do_clear();
    if (co_clr) begin
      ref_sum = 8'h00;
      ref_ovf = 1'b0;
    end
    r = ref_add(ref_sum, p);
    ref_sum = r.code;
    ref_ovf = ref_ovf | r.ovf;
    @(negedge clk);
    bus.acc_start = 1'b1;
    bus.prod_in   = p;
    bus.clear     = co_clr;
    @(posedge clk);
    @(negedge clk);
    bus.clear   = 1'b0;
    bus.prod_in = 8'($urandom);
    check("busy_run", bus.busy, 1);
    check("out_stable", bus.acc_out, last_out);
    lat = 0;
    while (!bus.acc_done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, r.lat);
    check("acc_out", bus.acc_out, r.code);
    check("ovf", bus.ovf, ref_ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", bus.acc_done, 1);
      check("hold_out", bus.acc_out, r.code);
      check("hold_busy", bus.busy, 1);
    end
    bus.acc_start = 1'b0;
    @(negedge clk);
    check("idle_done", bus.acc_done, 0);
    check("idle_busy", bus.busy, 0);
    last_out = r.code;
    $display("[TB] add prod=%02h clr=%0d -> acc_out=%02h ovf=%0d lat=%0d (model %02h/%0d/%0d)",
             p, co_clr, bus.acc_out, bus.ovf, lat, r.code, ref_ovf, r.lat);
  endtask

  typedef struct {
    logic       pre_clr;
    logic [7:0] prod;
    logic [7:0] exp_out;
    logic       exp_ovf;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear     = 1'b0;
    bus.acc_start = 1'b0;
    bus.prod_in   = 8'h00;

    // Fixed vectors: spec corner cases with hand-derived results.
    vecs[0] = '{1'b1, 8'h30, 8'h30, 1'b0, 3};
    vecs[1] = '{1'b0, 8'h30, 8'h40, 1'b0, 3};
    vecs[2] = '{1'b1, 8'h38, 8'h38, 1'b0, 3};
    vecs[3] = '{1'b0, 8'hB8, 8'h00, 1'b0, 3};
    vecs[4] = '{1'b1, 8'h40, 8'h40, 1'b0, 3};
    vecs[5] = '{1'b0, 8'hB8, 8'h20, 1'b0, 5};
    vecs[6] = '{1'b1, 8'h7F, 8'h7F, 1'b0, 3};
    vecs[7] = '{1'b0, 8'h7F, 8'h7F, 1'b1, 3};
    vecs[8] = '{1'b0, 8'h80, 8'h7F, 1'b1, 3};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out", bus.acc_out, 8'h00);
    check("rst_done", bus.acc_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].prod, vecs[i].pre_clr, 1'b0, 0);
      check("vec_out", bus.acc_out, vecs[i].exp_out);
      check("vec_ovf", bus.ovf, vecs[i].exp_ovf);
      check("vec_lat_model", ref_add(vecs[i].pre_clr ? 8'h00 : (i == 0 ? 8'h00 : vecs[i-1].exp_out),
                                     vecs[i].prod).lat, vecs[i].exp_lat);
    end
    do_clear();
    check("ovf_cleared", bus.ovf, 0);

    // Reset in the middle of NORM: outputs drop at once, no partial update.
    apply(8'h7F, 1'b0, 1'b0, 0);
    apply(8'h7F, 1'b0, 1'b0, 0);
    @(negedge clk);
    bus.acc_start = 1'b1;
    bus.prod_in   = 8'h30;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", bus.busy, 1);
    bus.acc_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", bus.acc_out, 8'h00);
    check("mid_rst_done", bus.acc_done, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_out", bus.acc_out, 8'h00);
    check("post_rst_busy", bus.busy, 0);
    $display("[TB] reset mid-NORM -> acc_out=%02h busy=%0d ovf=%0d", bus.acc_out, bus.busy, bus.ovf);
    ref_sum  = 8'h00;
    ref_ovf  = 1'b0;
    last_out = 8'h00;
    apply(8'h30, 1'b0, 1'b0, 0);
    check("post_rst_sum", bus.acc_out, 8'h30);

    // Clear together with start, then hold acc_start high.
    apply(8'h50, 1'b0, 1'b0, 0);
    apply(8'h38, 1'b0, 1'b1, 5);
    check("co_clear_out", bus.acc_out, 8'h38);

    // Randomized accumulation against the model.
    for (int n = 0; n < 80; n++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      apply(p, ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
